// File: rtl/alu_sequencer.sv
// Program sequencer for an external accumulator ALU: replays up to eight stored
// {Inst, A} entries on consecutive cycles, then captures the accumulator value.
module alu_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [3:0] len,
  input  logic       start,
  input  logic [3:0] alu_OUT,
  output logic [3:0] alu_A,
  output logic [1:0] alu_Inst,
  output logic       alu_RESET,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t     state;
  logic [5:0] prog [DEPTH];
  logic [2:0] pc;
  logic [2:0] last_pc;
  logic [3:0] eff_len;

  always_comb eff_len = (len > 4'd8) ? 4'd8 : len;

  always_comb busy = (state != IDLE);

  // Program store has no reset; writes are only accepted while not running.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) prog[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= IDLE;
      pc      <= '0;
      last_pc <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc      <= '0;
            last_pc <= 3'(eff_len - 4'd1);
            state   <= (eff_len == 4'd0) ? WAIT : RUN;
          end
        end
        RUN: begin
          pc <= pc + 3'd1;
          if (pc == last_pc) state <= WAIT;
        end
        WAIT: begin
          result <= alu_OUT;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue path is combinational from the registered pc so an entry reaches the
  // ALU in the same cycle its RUN slot begins; RESET forces the ALU clear at once.
  always_comb begin
    alu_RESET = 1'b1;
    alu_Inst  = '0;
    alu_A     = '0;
    if (state == RUN && !RESET) begin
      alu_RESET         = 1'b0;
      {alu_Inst, alu_A} = prog[pc];
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit accumulator ALU
// attached to the alu_* pins.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic [3:0] len = '0;
  logic       start = 1'b0;
  logic [3:0] alu_OUT;
  logic [3:0] alu_A;
  logic [1:0] alu_Inst;
  logic       alu_RESET;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;
  int lat;
  int n_iss;
  int n_done;
  logic [5:0] iss [16];
  logic [3:0] acc;

  alu_sequencer #(.DEPTH(8)) dut (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .alu_OUT(alu_OUT), .alu_A(alu_A), .alu_Inst(alu_Inst),
    .alu_RESET(alu_RESET), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Downstream accumulator: 00 add, 01 subtract, modulo 16, synchronous clear.
  always @(posedge clk) begin
    if (alu_RESET) acc <= '0;
    else if (alu_Inst == 2'b00) acc <= acc + alu_A;
    else if (alu_Inst == 2'b01) acc <= acc - alu_A;
  end
  assign alu_OUT = acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Raises start for one sampling edge and follows the run until done.
  // lat counts edges including the start-sampling one; returns in the done cycle.
  task automatic do_run(input logic [3:0] l);
    len = l; start = 1'b1; lat = 0; n_iss = 0;
    for (int i = 0; i < 16; i++) iss[i] = '0;
    while (lat < 30) begin
      tick();
      lat++;
      start = 1'b0; wr_en = 1'b0;
      if (!alu_RESET && n_iss < 16) begin iss[n_iss] = {alu_Inst, alu_A}; n_iss++; end
      if (done) break;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL rst_result: got %0d expected 0", result); end
    checks++; if (alu_RESET !== 1'b1) begin errors++; $display("FAIL rst_alu_reset: got %b expected 1", alu_RESET); end
    checks++; if ({alu_Inst, alu_A} !== 6'h00) begin errors++; $display("FAIL rst_issue: got %h expected 00", {alu_Inst, alu_A}); end
    RESET = 1'b0;
    tick();
    checks++; if (alu_RESET !== 1'b1) begin errors++; $display("FAIL idle_alu_reset: got %b expected 1", alu_RESET); end
  endtask

  task automatic test_basic();
    write_entry(3'd0, 6'h03);
    write_entry(3'd1, 6'h05);
    write_entry(3'd2, 6'h12);
    do_run(4'd3);
    checks++; if (lat !== 5) begin errors++; $display("FAIL s1_latency: got %0d expected 5", lat); end
    checks++; if (n_iss !== 3) begin errors++; $display("FAIL s1_issues: got %0d expected 3", n_iss); end
    checks++; if (iss[0] !== 6'h03) begin errors++; $display("FAIL s1_issue0: got %h expected 03", iss[0]); end
    checks++; if (iss[1] !== 6'h05) begin errors++; $display("FAIL s1_issue1: got %h expected 05", iss[1]); end
    checks++; if (iss[2] !== 6'h12) begin errors++; $display("FAIL s1_issue2: got %h expected 12", iss[2]); end
    checks++; if (result !== 4'd6) begin errors++; $display("FAIL s1_result: got %0d expected 6", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s1_busy_at_done: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL s1_done_pulse: got %b expected 0", done); end
    checks++; if (result !== 4'd6) begin errors++; $display("FAIL s1_result_hold: got %0d expected 6", result); end
  endtask

  task automatic test_wrap();
    write_entry(3'd0, 6'h0F);
    write_entry(3'd1, 6'h01);
    do_run(4'd2);
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL s2_add_wrap: got %0d expected 0", result); end
    write_entry(3'd0, 6'h11);
    do_run(4'd1);
    checks++; if (result !== 4'd15) begin errors++; $display("FAIL s2_sub_wrap: got %0d expected 15", result); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL s2_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8; i++) write_entry(3'(i), 6'(i + 1));
    len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if ({alu_RESET, alu_Inst, alu_A} !== 7'h04) begin errors++; $display("FAIL s3_run4_issue: got %h expected 04", {alu_RESET, alu_Inst, alu_A}); end
    RESET = 1'b1;
    #1;
    checks++; if (alu_RESET !== 1'b1) begin errors++; $display("FAIL s3_alu_reset_comb: got %b expected 1", alu_RESET); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s3_busy: got %b expected 0", busy); end
    checks++; if (alu_RESET !== 1'b1) begin errors++; $display("FAIL s3_alu_reset: got %b expected 1", alu_RESET); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL s3_result: got %0d expected 0", result); end
    RESET = 1'b0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) n_done++;
      tick();
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL s3_no_done: got %0d expected 0", n_done); end
    do_run(4'd8);
    checks++; if (n_iss !== 8) begin errors++; $display("FAIL s3_rerun_issues: got %0d expected 8", n_iss); end
    checks++; if (iss[7] !== 6'h08) begin errors++; $display("FAIL s3_rerun_last: got %h expected 08", iss[7]); end
    checks++; if (result !== 4'd4) begin errors++; $display("FAIL s3_rerun_result: got %0d expected 4", result); end
  endtask

  task automatic test_busy_ignore();
    len = 4'd3; start = 1'b1;
    tick();
    n_done = 0; n_iss = 0;
    for (int c = 1; c <= 10; c++) begin
      if (!alu_RESET) begin iss[n_iss] = {alu_Inst, alu_A}; n_iss++; end
      if (done) n_done++;
      if (c == 2) begin start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 6'h3F; end
      else begin start = 1'b0; wr_en = 1'b0; end
      tick();
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL s4_done_count: got %0d expected 1", n_done); end
    checks++; if (n_iss !== 3) begin errors++; $display("FAIL s4_issues: got %0d expected 3", n_iss); end
    checks++; if (iss[1] !== 6'h02) begin errors++; $display("FAIL s4_issue1: got %h expected 02", iss[1]); end
    checks++; if (result !== 4'd6) begin errors++; $display("FAIL s4_result: got %0d expected 6", result); end
    do_run(4'd2);
    checks++; if (iss[1] !== 6'h02) begin errors++; $display("FAIL s4_mem_kept: got %h expected 02", iss[1]); end
    checks++; if (result !== 4'd3) begin errors++; $display("FAIL s4_mem_result: got %0d expected 3", result); end
  endtask

  task automatic test_len_bounds();
    tick();
    do_run(4'd0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL s5_len0_latency: got %0d expected 2", lat); end
    checks++; if (n_iss !== 0) begin errors++; $display("FAIL s5_len0_issues: got %0d expected 0", n_iss); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL s5_len0_result: got %0d expected 0", result); end
    tick();
    do_run(4'd12);
    checks++; if (n_iss !== 8) begin errors++; $display("FAIL s5_len12_issues: got %0d expected 8", n_iss); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL s5_len12_latency: got %0d expected 10", lat); end
    checks++; if (result !== 4'd4) begin errors++; $display("FAIL s5_len12_result: got %0d expected 4", result); end
  endtask

  task automatic test_back_to_back();
    tick();
    do_run(4'd3);
    checks++; if (result !== 4'd6) begin errors++; $display("FAIL s6_first_result: got %0d expected 6", result); end
    do_run(4'd2);
    checks++; if (lat !== 4) begin errors++; $display("FAIL s6_second_latency: got %0d expected 4", lat); end
    checks++; if (iss[0] !== 6'h01) begin errors++; $display("FAIL s6_second_issue0: got %h expected 01", iss[0]); end
    checks++; if (result !== 4'd3) begin errors++; $display("FAIL s6_second_result: got %0d expected 3", result); end
  endtask

  task automatic test_write_with_start();
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 6'h09;
    do_run(4'd1);
    checks++; if (iss[0] !== 6'h09) begin errors++; $display("FAIL coinc_issue: got %h expected 09", iss[0]); end
    checks++; if (result !== 4'd9) begin errors++; $display("FAIL coinc_result: got %0d expected 9", result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_reset_mid_run();
    test_busy_ignore();
    test_len_bounds();
    test_back_to_back();
    test_write_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, number of program entries; address width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  program-write strobe.
REQ-005 wr_addr  input  3  program entry index.
REQ-006 wr_data  input  6  entry payload: [5:4] = Inst, [3:0] = A operand.
REQ-007 len  input  4  number of entries to execute, 0..8; values 9..15 are treated as 8.
REQ-008 start  input  1  run request, sampled in IDLE only.
REQ-009 alu_OUT  input  4  accumulator value returned by the downstream accumulator ALU.
REQ-010 alu_A  output  4  operand issued to the ALU.
REQ-011 alu_Inst  output  2  opcode issued to the ALU.
REQ-012 alu_RESET  output  1  accumulator clear, driven to the ALU RESET pin.
REQ-013 busy  output  1  high in RUN and WAIT.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 result  output  4  final accumulator value of the last run.

Function
REQ-016 Program store SHALL be an 8x6 register array, written on a cycle with wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, RUN, WAIT.
REQ-018 IDLE: alu_RESET=1, alu_A=0, alu_Inst=00; this keeps the ALU accumulator at 0 before every run.
REQ-019 IDLE -> RUN on start=1 with len>0; the program counter pc is cleared to 0.
REQ-020 IDLE -> WAIT on start=1 with len=0, issuing no entries.
REQ-021 RUN: alu_RESET=0; {alu_Inst, alu_A} = entry[pc], combinationally from registered pc; pc increments each cycle.
REQ-022 RUN -> WAIT in the cycle where pc = effective_len-1; exactly effective_len entries SHALL be issued on consecutive cycles.
REQ-023 WAIT: alu_RESET=1, alu_Inst=00, alu_A=0; at the WAIT edge result <= alu_OUT and done=1 for the following cycle; FSM -> IDLE.
REQ-024 Latency: done SHALL assert len+2 cycles after the start-sampling edge (2 cycles for len=0).
REQ-025 start SHALL be ignored while busy=1; a start in the same cycle as done SHALL be accepted, because the FSM is already in IDLE.
REQ-026 Program contents SHALL be retained across runs; result SHALL hold until the next WAIT capture.
REQ-027 Coincident wr_en and start in IDLE: the write completes, and the run reads the post-write contents.
REQ-028 The sequencer SHALL NOT interpret opcodes; accumulator arithmetic is 4-bit modulo-16 inside the ALU (00 add, 01 subtract).

Reset
REQ-029 RESET=1 SHALL force the following at the next edge: FSM=IDLE, pc=0, result=0, done=0, busy=0.
REQ-030 While RESET=1, alu_RESET SHALL be 1, including during RUN, which aborts the run without producing done.
REQ-031 RESET SHALL NOT clear the program store; contents after power-up are undefined until written.

Verification
REQ-032 Scenario 1: write {00,3},{00,5},{01,2}; len=3; pulse start -> alu_Inst/alu_A sequence 00/3, 00/5, 01/2 on 3 consecutive cycles; done 5 cycles after start; result=6.
REQ-033 Scenario 2: wrap-around: entries {00,15},{00,1}; len=2 -> result=0. Then entries {01,1}, len=1 -> result=15.
REQ-034 Scenario 3: RESET mid-run: len=8, assert RESET on the 4th RUN cycle -> busy=0 and alu_RESET=1 next cycle, no done, result=0; then rerun -> correct result with the program intact.
REQ-035 Scenario 4: start and wr_en pulsed while busy -> no restart, memory unchanged, single done.
REQ-036 Scenario 5: len=0 start -> done after 2 cycles, result=0, no RUN cycles. Then len=12 -> exactly 8 issues.
REQ-037 Scenario 6: back-to-back runs, with start asserted in the done cycle -> the second run begins immediately and the accumulator starts from 0.
